multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Main controller for the multicycle RV32I datapath: sequences fetch, decode, execute, memory and writeback.
- Drives every datapath strobe and mux select from its state and from the op_code, funct3, funct7 and Zero returned by the datapath.
- Provides memory wait states, halt on ECALL/EBREAK, illegal-opcode trap and a retire pulse for performance counting.

Parameters:
- MEM_WAIT, 1, cycles from address presented to memory output valid (>=1); used by FETCH and MEM_RD.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- op_code  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- Zero  in  1  ALU result == 0.
- adr_src  out  1  0 = PC, 1 = result.
- mem_write  out  1  data memory write strobe.
- IR_write  out  1  IR / old_PC load.
- reg_write  out  1  register file write.
- PC_write  out  1  PC load.
- result_src  out  2  0 = ALU_out, 1 = dmem_data, 2 = ALU_result.
- alu_src_a  out  2  0 = PC, 1 = old_PC, 2 = rs1 flop.
- alu_src_b  out  2  0 = rs2 flop, 1 = immext, 2 = const 4.
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- alu_control  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- halted  out  1  core stopped.
- illegal_instr  out  1  sticky, set on unknown opcode.
- retire  out  1  one-cycle pulse in the last cycle of each instruction.
- state_dbg  out  5  current state encoding.

Behaviour:
- Reset
  - While reset is high, state = FETCH, wait counter = 0, halted = 0, illegal_instr = 0.
  - All write strobes and retire are 0 immediately (asynchronous).
  - Reset mid-instruction abandons that instruction with no further write.
- Output decoding
  - Moore outputs decoded from state; ALU op and imm_src also depend on the IR fields.
  - imm_src is decoded from op_code in every state.
  - Unlisted strobes = 0; unlisted selects = 0.
- FETCH
  - adr_src = 0.
  - Stays MEM_WAIT cycles (counter), then -> IR_LOAD.
- IR_LOAD
  - IR_write = 1, alu_src_a = 0, alu_src_b = 2, ADD, result_src = 2, PC_write = 1 (PC += 4).
  - -> DECODE.
- DECODE
  - alu_src_a = 1, alu_src_b = 1, ADD; ALU_out = old_PC + imm, used as branch, JAL and AUIPC target.
  - Dispatch on op_code:
    - 0000011 / 0100011 -> MEM_ADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0110111 -> EXEC_U
    - 0010111 -> ALU_WB
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 1100011 -> BRANCH
    - 1110011 -> HALT
    - other -> HALT with illegal_instr = 1
- MEM_ADR
  - alu_src_a = 2, alu_src_b = 1, ADD.
  - Load -> MEM_RD; store -> MEM_WR.
- MEM_RD
  - adr_src = 1, result_src = 0; the ALU keeps rs1 + imm so ALU_out stays stable.
  - Lasts MEM_WAIT + 1 cycles (memory latency plus the dmem flop), then -> MEM_WB.
- MEM_WB
  - result_src = 1, reg_write = 1, retire = 1.
  - -> FETCH.
- MEM_WR
  - adr_src = 1, result_src = 0, mem_write = 1 for exactly one cycle; ALU held as in MEM_RD; retire = 1.
  - -> FETCH.
- EXEC_R and EXEC_I
  - alu_src_a = 2; alu_src_b = 0 (R) or 1 (I).
  - funct3 map: 000 ADD (SUB if R and funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7[5]), 110 OR, 111 AND.
  - -> ALU_WB.
- EXEC_U
  - alu_src_b = 1, PASS_B.
  - -> ALU_WB.
- ALU_WB
  - result_src = 0, reg_write = 1, retire = 1.
  - -> FETCH.
- JAL
  - result_src = 0, PC_write = 1.
  - Concurrently alu_src_a = 1, alu_src_b = 2, ADD, so ALU_out = old_PC + 4.
  - -> ALU_WB.
- JALR
  - alu_src_a = 2, alu_src_b = 1, ADD.
  - -> JALR_PC.
- JALR_PC
  - Same outputs as the JAL state.
  - -> ALU_WB.
- BRANCH
  - alu_src_a = 2, alu_src_b = 0, result_src = 0, retire = 1.
  - ALU op: BEQ/BNE = SUB, BLT/BGE = SLT, BLTU/BGEU = SLTU.
  - Taken condition:
    - BEQ: Zero
    - BNE: !Zero
    - BLT / BLTU: !Zero
    - BGE / BGEU: Zero
    - funct3 010 / 011: never taken
  - PC_write = taken.
  - -> FETCH.
- HALT
  - halted = 1, all strobes 0, no retire.
  - Remains in HALT until reset.
- Cycle counts at MEM_WAIT = 1:
  - R / I / LUI / JAL / JALR: 5 (JALR 6).
  - AUIPC: 4.
  - Branch: 4.
  - Store: 5.
  - Load: 7.
- Wait counter: width is ceil(log2(MEM_WAIT + 2)); it clears on every state change.

Test Plan:
- Reset released, IR = addi x1,x0,5 (0x00500093) -> states FETCH, IR_LOAD, DECODE, EXEC_I, ALU_WB; reg_write high in cycle 5; PC_write high only in cycle 2; retire pulses once.
- lw (op 0000011), MEM_WAIT = 2 -> FETCH 2 cycles, MEM_RD 3 cycles, MEM_WB with result_src = 1 and reg_write; adr_src = 1 throughout MEM_RD; 9 cycles total.
- sw (op 0100011) -> mem_write high exactly one cycle in MEM_WR with adr_src = 1; reg_write never asserted.
- beq with Zero = 1 -> PC_write = 1 in BRANCH. bne with Zero = 1 -> PC_write = 0. bge with Zero = 0 -> PC_write = 0. alu_control = SLT for bge.
- jal -> PC_write in the JAL state with result_src = 0, then reg_write in ALU_WB. Assert reset mid-EXEC_R -> outputs 0 immediately, state_dbg = FETCH.
- op_code 0x7F -> halted = 1 and illegal_instr = 1 after DECODE, strobes stay 0 for 20 cycles. ecall (0x73) -> halted = 1, illegal_instr = 0.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle RV32I controller and its datapath.
//   master : controller side - takes IR fields and Zero, drives strobes/selects
//   slave  : datapath side   - mirror of master
// Signals:
//   op_code/funct3/funct7 : IR fields, Zero : ALU result == 0
//   adr_src, mem_write, IR_write, reg_write, PC_write : strobes/selects
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control : mux/ALU controls
//   halted, illegal_instr, retire, state_dbg : status
interface multicycle_control_fsm_if;
    logic [6:0] op_code;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       adr_src;
    logic       mem_write;
    logic       IR_write;
    logic       reg_write;
    logic       PC_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       halted;
    logic       illegal_instr;
    logic       retire;
    logic [4:0] state_dbg;

    modport master (
        input  op_code, funct3, funct7, Zero,
        output adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, halted,
               illegal_instr, retire, state_dbg
    );

    modport slave (
        output op_code, funct3, funct7, Zero,
        input  adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, halted,
               illegal_instr, retire, state_dbg
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main controller of the multicycle RV32I datapath. Sequences fetch, decode,
// execute, memory and writeback; inserts MEM_WAIT wait states on memory
// reads, halts on ECALL/EBREAK and traps unknown opcodes.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : controller side of the control bus (IR fields in, strobes out)
module multicycle_control_fsm #(
    parameter int MEM_WAIT = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    multicycle_control_fsm_if.master        bus
);
    localparam int CW = $clog2(MEM_WAIT + 2);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef enum logic [4:0] {
        FETCH, IR_LOAD, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R,
        EXEC_I, EXEC_U, ALU_WB, JAL, JALR, JALR_PC, BRANCH, HALT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          halted_q;
    logic          illegal_q;
    logic [3:0]    exec_op;
    logic [3:0]    branch_op;
    logic          taken;
    logic          unused_f7;

    assign unused_f7 = ^{bus.funct7[6], bus.funct7[4:0]};

    // Counter defaults to 0 so it clears on every state change; only the
    // two wait states increment it while they hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH:
                    if (wait_cnt == CW'(MEM_WAIT - 1)) state <= IR_LOAD;
                    else wait_cnt <= wait_cnt + CW'(1);
                IR_LOAD: state <= DECODE;
                DECODE:
                    case (bus.op_code)
                        OP_LOAD, OP_STORE: state <= MEM_ADR;
                        OP_R:              state <= EXEC_R;
                        OP_I:              state <= EXEC_I;
                        OP_LUI:            state <= EXEC_U;
                        OP_AUIPC:          state <= ALU_WB;
                        OP_JAL:            state <= JAL;
                        OP_JALR:           state <= JALR;
                        OP_BRANCH:         state <= BRANCH;
                        OP_SYSTEM: begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end
                        default: begin
                            state     <= HALT;
                            halted_q  <= 1'b1;
                            illegal_q <= 1'b1;
                        end
                    endcase
                MEM_ADR: state <= (bus.op_code == OP_STORE) ? MEM_WR : MEM_RD;
                // Memory latency plus one cycle for the dmem output flop.
                MEM_RD:
                    if (wait_cnt == CW'(MEM_WAIT)) state <= MEM_WB;
                    else wait_cnt <= wait_cnt + CW'(1);
                MEM_WB, MEM_WR, ALU_WB, BRANCH: state <= FETCH;
                EXEC_R, EXEC_I, EXEC_U:         state <= ALU_WB;
                JAL, JALR_PC:                   state <= ALU_WB;
                JALR:                           state <= JALR_PC;
                HALT:                           state <= HALT;
                default:                        state <= FETCH;
            endcase
        end
    end

    always_comb begin
        exec_op = ALU_ADD;
        case (bus.funct3)
            3'b000: exec_op = (state == EXEC_R && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: exec_op = ALU_SLL;
            3'b010: exec_op = ALU_SLT;
            3'b011: exec_op = ALU_SLTU;
            3'b100: exec_op = ALU_XOR;
            3'b101: exec_op = bus.funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: exec_op = ALU_OR;
            default: exec_op = ALU_AND;
        endcase
    end

    // SLT/SLTU leave 0 (Zero=1) when rs1 >= rs2, so LT takes on !Zero.
    always_comb begin
        branch_op = ALU_ADD;
        taken     = 1'b0;
        case (bus.funct3)
            3'b000: begin branch_op = ALU_SUB;  taken = bus.Zero;  end
            3'b001: begin branch_op = ALU_SUB;  taken = !bus.Zero; end
            3'b100: begin branch_op = ALU_SLT;  taken = !bus.Zero; end
            3'b101: begin branch_op = ALU_SLT;  taken = bus.Zero;  end
            3'b110: begin branch_op = ALU_SLTU; taken = !bus.Zero; end
            3'b111: begin branch_op = ALU_SLTU; taken = bus.Zero;  end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.op_code)
            OP_STORE:         bus.imm_src = 3'b001;
            OP_BRANCH:        bus.imm_src = 3'b010;
            OP_LUI, OP_AUIPC: bus.imm_src = 3'b011;
            OP_JAL:           bus.imm_src = 3'b100;
            default:          bus.imm_src = 3'b000;
        endcase
    end

    always_comb begin
        bus.adr_src     = 1'b0;
        bus.mem_write   = 1'b0;
        bus.IR_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.PC_write    = 1'b0;
        bus.result_src  = 2'd0;
        bus.alu_src_a   = 2'd0;
        bus.alu_src_b   = 2'd0;
        bus.alu_control = ALU_ADD;
        bus.retire      = 1'b0;
        case (state)
            FETCH: ;
            IR_LOAD: begin
                bus.IR_write   = 1'b1;
                bus.alu_src_b  = 2'd2;
                bus.result_src = 2'd2;
                bus.PC_write   = 1'b1;
            end
            DECODE: begin
                bus.alu_src_a = 2'd1;
                bus.alu_src_b = 2'd1;
            end
            MEM_ADR, JALR: begin
                bus.alu_src_a = 2'd2;
                bus.alu_src_b = 2'd1;
            end
            // ALU keeps rs1 + imm so the registered address stays stable.
            MEM_RD: begin
                bus.adr_src   = 1'b1;
                bus.alu_src_a = 2'd2;
                bus.alu_src_b = 2'd1;
            end
            MEM_WR: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
                bus.alu_src_a = 2'd2;
                bus.alu_src_b = 2'd1;
                bus.retire    = 1'b1;
            end
            MEM_WB: begin
                bus.result_src = 2'd1;
                bus.reg_write  = 1'b1;
                bus.retire     = 1'b1;
            end
            EXEC_R, EXEC_I: begin
                bus.alu_src_a   = 2'd2;
                bus.alu_src_b   = (state == EXEC_I) ? 2'd1 : 2'd0;
                bus.alu_control = exec_op;
            end
            EXEC_U: begin
                bus.alu_src_b   = 2'd1;
                bus.alu_control = ALU_PASS;
            end
            ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.retire    = 1'b1;
            end
            // PC takes the target in ALU_out while the ALU forms old_PC + 4
            // for the link register written in ALU_WB.
            JAL, JALR_PC: begin
                bus.PC_write  = 1'b1;
                bus.alu_src_a = 2'd1;
                bus.alu_src_b = 2'd2;
            end
            BRANCH: begin
                bus.alu_src_a   = 2'd2;
                bus.alu_control = branch_op;
                bus.PC_write    = taken;
                bus.retire      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.halted        = halted_q;
    assign bus.illegal_instr = illegal_q;
    assign bus.state_dbg     = state;
endmodule
